// File: rtl/logic_cluster_pkg.sv
// logic_cluster_pkg: derived widths, config-field offsets and direction indices for logic_cluster.
// LOGIC_CLUSTER_FF_INIT_EN adds one init bit to the top of every BLE field.
package logic_cluster_pkg;
  localparam int DIR_LEFT  = 0;
  localparam int DIR_RIGHT = 1;
  localparam int DIR_UP    = 2;
  localparam int DIR_DOWN  = 3;
`ifdef LOGIC_CLUSTER_FF_INIT_EN
  localparam int INIT_BITS = 1;
`else
  localparam int INIT_BITS = 0;
`endif
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic int sel_w(input int n, input int w);
    return clog2(4 * w + n);
  endfunction
  function automatic int idx_w(input int n);
    return n > 1 ? clog2(n) : 1;
  endfunction
  function automatic int ble_bits(input int k, input int n, input int w);
    return (1 << k) + 1 + k * sel_w(n, w) + INIT_BITS;
  endfunction
  function automatic int cfg_bits(input int k, input int n, input int w);
    return n * ble_bits(k, n, w) + 4 * (1 + idx_w(n));
  endfunction
  function automatic int sel_off(input int k, input int n, input int w, input int j);
    return (1 << k) + 1 + j * sel_w(n, w);
  endfunction
  function automatic int dir_off(input int k, input int n, input int w, input int d);
    return n * ble_bits(k, n, w) + d * (1 + idx_w(n));
  endfunction
endpackage

// File: rtl/logic_cluster_if.sv
// logic_cluster_if: routing buses, config chain and direction outputs of one cluster tile.
interface logic_cluster_if #(parameter int W = 4);
  logic [W-1:0] left_in, right_in, up_in, down_in;
  logic cfg_en, cfg_din, cfg_commit;
  logic cfg_dout, cfg_ready, cfg_err, cfg_active;
  logic left, right, up, down;
  modport master (
    output left_in, right_in, up_in, down_in, cfg_en, cfg_din, cfg_commit,
    input  cfg_dout, cfg_ready, cfg_err, cfg_active, left, right, up, down
  );
  modport slave (
    input  left_in, right_in, up_in, down_in, cfg_en, cfg_din, cfg_commit,
    output cfg_dout, cfg_ready, cfg_err, cfg_active, left, right, up, down
  );
endinterface

// File: rtl/logic_cluster_ble.sv
// cluster_ble: K-input LUT with output FF, ff_sel output mux and optional init load on commit.
module cluster_ble #(
  parameter int K = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [2**K-1:0] truth,
  input  logic            ff_sel,
  input  logic            init,
  input  logic            load_init,
  input  logic [K-1:0]    lut_in,
  output logic            q,
  output logic            ble_out
);
  logic lut_o;
  assign lut_o = truth[lut_in];
  assign ble_out = ff_sel ? q : lut_o;
  always_ff @(posedge clk) begin
    if (reset) q <= 1'b0;
    else q <= load_init ? init : lut_o;
  end
endmodule

// File: rtl/logic_cluster.sv
// logic_cluster: N BLEs with routed LUT inputs, direction outputs and a shadow config chain.
// LOGIC_CLUSTER_FF_INIT_EN: each BLE FF loads a configured init bit on every successful commit.
module logic_cluster
  import logic_cluster_pkg::*;
#(
  parameter int K = 4,
  parameter int N = 2,
  parameter int W = 4
) (
  input logic clk,
  input logic reset,
  logic_cluster_if.slave bus
);
  localparam int SELW     = sel_w(N, W);
  localparam int IDXW     = idx_w(N);
  localparam int BLE_BITS = ble_bits(K, N, W);
  localparam int CFG_BITS = cfg_bits(K, N, W);
  localparam int CNTW     = clog2(CFG_BITS + 1);
  localparam int SRC_PAD  = 2**SELW;
  localparam int BLE_PAD  = 2**IDXW;
  logic [CFG_BITS-1:0] shadow, active;
  logic [CNTW-1:0]     cnt;
  logic                commit_ok;
  logic [N-1:0]        ble_q, ble_out;
  logic [SRC_PAD-1:0]  src;
  logic [BLE_PAD-1:0]  ble_sel;
  logic [3:0]          dir_out;
  assign bus.cfg_ready = cnt == CNTW'(CFG_BITS);
  assign bus.cfg_dout  = shadow[0];
  assign commit_ok     = bus.cfg_commit & bus.cfg_ready;
  // zero padding makes out-of-range selects and BLE indices read constant 0
  assign src     = SRC_PAD'({ble_q, bus.down_in, bus.up_in, bus.right_in, bus.left_in});
  assign ble_sel = BLE_PAD'(ble_out);
  always_ff @(posedge clk) begin
    if (reset) begin
      shadow         <= '0;
      active         <= '0;
      cnt            <= '0;
      bus.cfg_err    <= 1'b0;
      bus.cfg_active <= 1'b0;
    end else begin
      if (bus.cfg_en) shadow <= {bus.cfg_din, shadow[CFG_BITS-1:1]};
      if (commit_ok) begin
        active         <= shadow;
        cnt            <= CNTW'(bus.cfg_en);
        bus.cfg_active <= 1'b1;
      end else if (bus.cfg_en && !bus.cfg_ready) begin
        cnt <= cnt + 1'b1;
      end
      bus.cfg_err <= bus.cfg_commit & ~bus.cfg_ready;
    end
  end
  for (genvar i = 0; i < N; i++) begin : g_ble
    localparam int B = i * BLE_BITS;
    logic [K-1:0] lut_in;
    logic         init, load_init;
    for (genvar j = 0; j < K; j++) begin : g_in
      assign lut_in[j] = src[active[B + sel_off(K, N, W, j) +: SELW]];
    end
`ifdef LOGIC_CLUSTER_FF_INIT_EN
    assign init      = active[B + BLE_BITS - 1];
    assign load_init = commit_ok;
`else
    assign init      = 1'b0;
    assign load_init = 1'b0;
`endif
    cluster_ble #(.K(K)) u_ble (
      .clk      (clk),
      .reset    (reset),
      .truth    (active[B +: 2**K]),
      .ff_sel   (active[B + 2**K]),
      .init     (init),
      .load_init(load_init),
      .lut_in   (lut_in),
      .q        (ble_q[i]),
      .ble_out  (ble_out[i])
    );
  end
  for (genvar i = 0; i < 4; i++) begin : g_dir
    localparam int D = dir_off(K, N, W, i);
    logic [IDXW-1:0] idx;
    assign idx        = active[D + 1 +: IDXW];
    assign dir_out[i] = active[D] & ble_sel[idx];
  end
  assign bus.left  = dir_out[DIR_LEFT];
  assign bus.right = dir_out[DIR_RIGHT];
  assign bus.up    = dir_out[DIR_UP];
  assign bus.down  = dir_out[DIR_DOWN];
endmodule

// File: tb/tb_logic_cluster.sv
// tb_logic_cluster: directed bench for logic_cluster (default build, K=4 N=2 W=4, 82-bit chain).
module tb_logic_cluster;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  logic_cluster_if #(.W(4)) bus0 ();
  logic_cluster_if #(.W(4)) bus1 ();
  assign bus1.cfg_en     = bus0.cfg_en;
  assign bus1.cfg_commit = bus0.cfg_commit;
  assign bus1.cfg_din    = bus0.cfg_dout;
  logic_cluster #(.K(4), .N(2), .W(4)) u0 (.clk(clk), .reset(reset), .bus(bus0));
  logic_cluster #(.K(4), .N(2), .W(4)) u1 (.clk(clk), .reset(reset), .bus(bus1));
  logic [3:0] o0, o1;
  assign o0 = {bus0.down, bus0.up, bus0.right, bus0.left};
  assign o1 = {bus1.down, bus1.up, bus1.right, bus1.left};
  // layout: t0[15:0] f0[16] sels0[36:17] t1[52:37] f1[53] sels1[73:54] dirs[81:74]
  function automatic logic [81:0] mk(input logic [15:0] t0, input logic f0, input logic [19:0] s0,
                                     input logic [15:0] t1, input logic f1, input logic [19:0] s1,
                                     input logic [7:0] dirs);
    return {dirs, s1, f1, t1, s0, f0, t0};
  endfunction
  logic [81:0] and_c, and_r, tog, mix, b_c;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic shift(input logic [163:0] s, input int lo, input int hi, input bit chk_dout);
    for (int i = lo; i <= hi; i++) begin
      bus0.cfg_en  = 1'b1;
      bus0.cfg_din = s[i];
      tick();
      if (chk_dout && i >= 90 && i <= 97) check($sformatf("dout_lag_%0d", i), 8'(bus0.cfg_dout), 8'(s[i-81]));
    end
    bus0.cfg_en = 1'b0;
  endtask
  task automatic commit();
    bus0.cfg_commit = 1'b1;
    tick();
    bus0.cfg_commit = 1'b0;
  endtask
  initial begin
    and_c = mk(16'h8000, 1'b0, {5'd3, 5'd2, 5'd1, 5'd0}, 16'h0, 1'b0, 20'h0, 8'b00_00_00_01);
    and_r = mk(16'h8000, 1'b1, {5'd3, 5'd2, 5'd1, 5'd0}, 16'h0, 1'b0, 20'h0, 8'b00_00_00_01);
    tog   = mk(16'h5555, 1'b1, {5'd31, 5'd31, 5'd31, 5'd16}, 16'h0, 1'b0, 20'h0, 8'b00_00_00_01);
    mix   = mk(16'h0001, 1'b0, {4{5'd20}}, 16'hAAAA, 1'b0, {5'd31, 5'd31, 5'd31, 5'd10}, 8'b10_11_11_01);
    b_c   = mk(16'hAAAA, 1'b0, {5'd31, 5'd31, 5'd31, 5'd13}, 16'h0, 1'b0, 20'h0, 8'b01_00_00_00);
    reset = 1'b1;
    bus0.cfg_en = 1'b0; bus0.cfg_din = 1'b0; bus0.cfg_commit = 1'b0;
    bus0.left_in = 4'($urandom); bus0.right_in = 4'($urandom);
    bus0.up_in = 4'($urandom); bus0.down_in = 4'($urandom);
    bus1.left_in = 4'($urandom); bus1.right_in = 4'($urandom);
    bus1.up_in = 4'($urandom); bus1.down_in = 4'($urandom);
    tick(); tick();
    check("rst_outs", 8'(o0), 8'h0);
    check("rst_ready", 8'(bus0.cfg_ready), 8'h0);
    check("rst_active", 8'(bus0.cfg_active), 8'h0);
    check("rst_err", 8'(bus0.cfg_err), 8'h0);
    check("rst_dout", 8'(bus0.cfg_dout), 8'h0);
    reset = 1'b0;
    bus0.left_in = 4'hF; bus0.right_in = 4'h0; bus0.up_in = 4'h0; bus0.down_in = 4'h0;
    tick();
    check("idle_outs", 8'(o0), 8'h0);
    // combinational AND of left_in on left
    shift({82'h0, and_c}, 0, 81, 1'b0);
    check("and_ready", 8'(bus0.cfg_ready), 8'h1);
    check("and_pre_active", 8'(bus0.cfg_active), 8'h0);
    check("and_pre_outs", 8'(o0), 8'h0);
    commit();
    check("and_outs_F", 8'(o0), 8'h1);
    check("and_active", 8'(bus0.cfg_active), 8'h1);
    check("and_ready_clr", 8'(bus0.cfg_ready), 8'h0);
    bus0.left_in = 4'hE; #1;
    check("and_outs_E", 8'(o0), 8'h0);
    bus0.left_in = 4'h7; #1;
    check("and_outs_7", 8'(o0), 8'h0);
    bus0.left_in = 4'hF; #1;
    check("and_outs_F2", 8'(o0), 8'h1);
    // same function through the FF
    shift({82'h0, and_r}, 0, 81, 1'b0);
    commit();
    bus0.left_in = 4'h0; tick();
    check("reg_lo", 8'(o0), 8'h0);
    bus0.left_in = 4'hF; #1;
    check("reg_hold_lo", 8'(o0), 8'h0);
    tick();
    check("reg_hi", 8'(o0), 8'h1);
    bus0.left_in = 4'h3; #1;
    check("reg_hold_hi", 8'(o0), 8'h1);
    tick();
    check("reg_lo2", 8'(o0), 8'h0);
    // short commit is rejected
    bus0.left_in = 4'hF; tick(); tick();
    shift({82'h0, and_c}, 0, 80, 1'b0);
    check("short_ready", 8'(bus0.cfg_ready), 8'h0);
    commit();
    check("short_err", 8'(bus0.cfg_err), 8'h1);
    check("short_active", 8'(bus0.cfg_active), 8'h1);
    bus0.left_in = 4'h0; #1;
    check("short_still_reg", 8'(o0), 8'h1);
    tick();
    check("short_err_clr", 8'(bus0.cfg_err), 8'h0);
    check("short_reg_lo", 8'(o0), 8'h0);
    shift({82'h0, and_c}, 81, 81, 1'b0);
    check("full_ready", 8'(bus0.cfg_ready), 8'h1);
    // commit while shifting the first bit of the next config
    bus0.cfg_commit = 1'b1; bus0.cfg_en = 1'b1; bus0.cfg_din = tog[0];
    tick();
    bus0.cfg_commit = 1'b0; bus0.cfg_en = 1'b0;
    check("full_err", 8'(bus0.cfg_err), 8'h0);
    check("full_ready_clr", 8'(bus0.cfg_ready), 8'h0);
    bus0.left_in = 4'hF; #1;
    check("full_comb_F", 8'(o0), 8'h1);
    bus0.left_in = 4'hE; #1;
    check("full_comb_E", 8'(o0), 8'h0);
    // toggle: BLE0 Q fed back through an inverter
    bus0.left_in = 4'h0;
    shift({82'h0, tog}, 1, 80, 1'b0);
    check("tog_ready_80", 8'(bus0.cfg_ready), 8'h0);
    shift({82'h0, tog}, 81, 81, 1'b0);
    check("tog_ready", 8'(bus0.cfg_ready), 8'h1);
    commit();
    check("tog_0", 8'(o0), 8'h0);
    tick(); check("tog_1", 8'(o0), 8'h1);
    tick(); check("tog_2", 8'(o0), 8'h0);
    tick(); check("tog_3", 8'(o0), 8'h1);
    // out-of-range selects, BLE1 routing to right/up, disabled down
    shift({82'h0, mix}, 0, 81, 1'b0);
    commit();
    bus0.left_in = 4'hF; bus0.right_in = 4'hF; bus0.down_in = 4'hF; bus0.up_in = 4'h4; #1;
    check("mix_up4", 8'(o0), 8'b0111);
    bus0.up_in = 4'hB; #1;
    check("mix_upB", 8'(o0), 8'b0001);
    bus0.up_in = 4'hF; #1;
    check("mix_upF", 8'(o0), 8'b0111);
    // two chained clusters, downstream segment first
    shift({and_c, b_c}, 0, 163, 1'b1);
    check("chain_ready0", 8'(bus0.cfg_ready), 8'h1);
    check("chain_ready1", 8'(bus1.cfg_ready), 8'h1);
    commit();
    bus0.left_in = 4'hF; bus1.left_in = 4'hF; bus1.down_in = 4'h2; #1;
    check("chain_a_F", 8'(o0), 8'b0001);
    check("chain_b_2", 8'(o1), 8'b1000);
    bus0.left_in = 4'h7; bus1.down_in = 4'hD; #1;
    check("chain_a_7", 8'(o0), 8'b0000);
    check("chain_b_D", 8'(o1), 8'b0000);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
